// File: rtl/block_word_packer_384.sv
// Collects WORDS 32-bit words (first word most significant) into one block and
// presents it on block_out with a single-cycle write_en pulse for the block memory.
module block_word_packer_384 #(
    parameter int unsigned WORDS = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic [32*WORDS-1:0]   block_out,
    output logic                  write_en,
    output logic                  busy,
    output logic [3:0]            word_count
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLOCK_W = WORD_W * WORDS;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t             state;
    logic [BLOCK_W-1:0] shreg;
    logic [BLOCK_W-1:0] shifted;

    // Next shift-register image if the offered word is taken this cycle.
    assign shifted = {shreg[BLOCK_W-WORD_W-1:0], word_in};

    // Control FSM with registered handshake, status and block outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            shreg      <= '0;
            block_out  <= '0;
            word_count <= '0;
            write_en   <= 1'b0;
            word_ready <= 1'b0;
            busy       <= 1'b0;
        end else begin
            write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        shreg      <= '0;
                        word_count <= '0;
                        word_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    // Abort wins over a word offered in the same cycle.
                    if (abort) begin
                        state      <= IDLE;
                        word_count <= '0;
                        word_ready <= 1'b0;
                        busy       <= 1'b0;
                    end else if (word_valid) begin
                        shreg <= shifted;
                        if (word_count == LAST_IDX) begin
                            state      <= WRITE;
                            block_out  <= shifted;
                            word_count <= '0;
                            word_ready <= 1'b0;
                            write_en   <= 1'b1;
                        end else begin
                            word_count <= word_count + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    word_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
